operand_fwd_stage: RTL and testbench

OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

---
 rtl/operand_fwd_stage_pkg.sv | 28 ++
 rtl/operand_fwd_stage_fwd_mux.sv | 36 +++
 rtl/operand_fwd_stage.sv | 156 +++++++++++++++
 tb/tb_operand_fwd_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fwd_stage_pkg.sv
// ----------------------------------------------------------------------------
// operand_fwd_stage_pkg
// Shared pipeline constants: forwarding-code encodings (produced by the hazard
// unit, consumed by the operand muxes) and write-back select encodings.
// ----------------------------------------------------------------------------
package operand_fwd_stage_pkg;

  localparam int XLEN = 32;

  // Forwarding codes. Codes not listed here (001/011/101) fall back to the
  // register-file value.
  localparam logic [2:0] FWD_RF     = 3'b000;
  localparam logic [2:0] FWD_EX     = 3'b010;
  localparam logic [2:0] FWD_MEM    = 3'b100;
  localparam logic [2:0] FWD_WB_ALU = 3'b110;
  localparam logic [2:0] FWD_WB_MEM = 3'b111;

  // Write-back source select.
  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;

  // Any non-zero code counts as a forwarding request for statistics, even
  // the reserved codes that resolve to the register file.
  function automatic logic is_fwd_code(input logic [2:0] code);
    return code != FWD_RF;
  endfunction

endpackage

// File: rtl/operand_fwd_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Purely combinational operand selector for one source operand.
// Ports:
//   code        - 3-bit forwarding code from the hazard unit
//   rf_val      - register-file read data
//   ex_val      - EX-stage ALU result
//   mem_val     - MEM-stage ALU result
//   wb_alu_val  - WB-stage ALU result
//   wb_mem_val  - WB-stage load data
//   op          - selected operand
// ----------------------------------------------------------------------------
module fwd_mux
  import operand_fwd_stage_pkg::*;
(
  input  logic [2:0]      code,
  input  logic [XLEN-1:0] rf_val,
  input  logic [XLEN-1:0] ex_val,
  input  logic [XLEN-1:0] mem_val,
  input  logic [XLEN-1:0] wb_alu_val,
  input  logic [XLEN-1:0] wb_mem_val,
  output logic [XLEN-1:0] op
);

  always_comb begin
    op = rf_val;
    case (code)
      FWD_EX:     op = ex_val;
      FWD_MEM:    op = mem_val;
      FWD_WB_ALU: op = wb_alu_val;
      FWD_WB_MEM: op = wb_mem_val;
      default:    op = rf_val;
    endcase
  end

endmodule

// File: rtl/operand_fwd_stage.sv
// ----------------------------------------------------------------------------
// operand_fwd_stage
// ID-stage operand forwarding plus the ID/EX pipeline register.
// Optional feature macro: FWD_STATS_EN adds stall/forward event counters.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   id_valid/id_rd/id_regwr/id_wbsel - ID instruction control
//   id_rs1val/id_rs2val        - register-file read data
//   rs1val_cont/rs2val_cont    - forwarding codes per operand
//   stall, flush               - hazard-unit stall, branch/jump squash
//   ex_alu_res, mem_alu_res, wb_alu_res, wb_mem_data - forwarding sources
//   ex_op1/ex_op2/ex_rd/ex_regwr/ex_wbsel/ex_valid   - ID/EX register
//   id_hold                    - freezes PC and IF/ID
//   stall_cnt, fwd_cnt         - (FWD_STATS_EN only) saturating counters
// ----------------------------------------------------------------------------
module operand_fwd_stage
  import operand_fwd_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rd,
  input  logic        id_regwr,
  input  logic [1:0]  id_wbsel,
  input  logic [31:0] id_rs1val,
  input  logic [31:0] id_rs2val,
  input  logic [2:0]  rs1val_cont,
  input  logic [2:0]  rs2val_cont,
  input  logic        stall,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] wb_alu_res,
  input  logic [31:0] wb_mem_data,
  input  logic        flush,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [4:0]  ex_rd,
  output logic        ex_regwr,
  output logic [1:0]  ex_wbsel,
  output logic        ex_valid,
  output logic        id_hold
`ifdef FWD_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] fwd_cnt
`endif
);

  logic [31:0] op1_sel;
  logic [31:0] op2_sel;
  logic        load;

  logic [31:0] ex_op1_q,   ex_op1_d;
  logic [31:0] ex_op2_q,   ex_op2_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic        ex_regwr_q, ex_regwr_d;
  logic [1:0]  ex_wbsel_q, ex_wbsel_d;
  logic        ex_valid_q, ex_valid_d;

  fwd_mux u_mux_rs1 (
    .code       (rs1val_cont),
    .rf_val     (id_rs1val),
    .ex_val     (ex_alu_res),
    .mem_val    (mem_alu_res),
    .wb_alu_val (wb_alu_res),
    .wb_mem_val (wb_mem_data),
    .op         (op1_sel)
  );

  fwd_mux u_mux_rs2 (
    .code       (rs2val_cont),
    .rf_val     (id_rs2val),
    .ex_val     (ex_alu_res),
    .mem_val    (mem_alu_res),
    .wb_alu_val (wb_alu_res),
    .wb_mem_val (wb_mem_data),
    .op         (op2_sel)
  );

  // A flush kills the instruction outright, so it must not also freeze fetch.
  assign id_hold = stall & id_valid & ~flush;
  // Everything that is not a real, unstalled, unflushed instruction is a bubble.
  assign load    = id_valid & ~stall & ~flush;

  always_comb begin
    // Bubble by default; operands keep their old value to avoid needless toggling.
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_rd_d    = 5'd0;
    ex_regwr_d = 1'b0;
    ex_wbsel_d = WBSEL_ALU;
    ex_valid_d = 1'b0;
    if (load) begin
      ex_op1_d   = op1_sel;
      ex_op2_d   = op2_sel;
      ex_rd_d    = id_rd;
      ex_regwr_d = id_regwr & (id_rd != 5'd0);  // never advertise a write to x0
      ex_wbsel_d = id_wbsel;
      ex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_rd_q    <= '0;
      ex_regwr_q <= 1'b0;
      ex_wbsel_q <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_rd_q    <= ex_rd_d;
      ex_regwr_q <= ex_regwr_d;
      ex_wbsel_q <= ex_wbsel_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_op1   = ex_op1_q;
  assign ex_op2   = ex_op2_q;
  assign ex_rd    = ex_rd_q;
  assign ex_regwr = ex_regwr_q;
  assign ex_wbsel = ex_wbsel_q;
  assign ex_valid = ex_valid_q;

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q,   fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (id_hold && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (load && (is_fwd_code(rs1val_cont) || is_fwd_code(rs2val_cont)) &&
        (fwd_cnt_q != 16'hFFFF))
      fwd_cnt_d = fwd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fwd_stage.sv
// ----------------------------------------------------------------------------
// tb_operand_fwd_stage
// Scoreboard bench: the stimulus process predicts each edge's ID/EX contents
// from a reference model and queues them; a monitor compares after each edge.
// Build with FWD_STATS_EN defined to include the statistics counters.
// ----------------------------------------------------------------------------
module tb_operand_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_regwr;
  logic [1:0]  id_wbsel;
  logic [31:0] id_rs1val, id_rs2val;
  logic [2:0]  rs1val_cont, rs2val_cont;
  logic        stall, flush;
  logic [31:0] ex_alu_res, mem_alu_res, wb_alu_res, wb_mem_data;
  logic [31:0] ex_op1, ex_op2;
  logic [4:0]  ex_rd;
  logic        ex_regwr;
  logic [1:0]  ex_wbsel;
  logic        ex_valid;
  logic        id_hold;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        regwr;
    logic [1:0]  wbsel;
    logic        valid;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_op1, m_op2;
  int          m_sc, m_fc;

  always #5 clk = ~clk;

  operand_fwd_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regwr    (id_regwr),
    .id_wbsel    (id_wbsel),
    .id_rs1val   (id_rs1val),
    .id_rs2val   (id_rs2val),
    .rs1val_cont (rs1val_cont),
    .rs2val_cont (rs2val_cont),
    .stall       (stall),
    .ex_alu_res  (ex_alu_res),
    .mem_alu_res (mem_alu_res),
    .wb_alu_res  (wb_alu_res),
    .wb_mem_data (wb_mem_data),
    .flush       (flush),
    .ex_op1      (ex_op1),
    .ex_op2      (ex_op2),
    .ex_rd       (ex_rd),
    .ex_regwr    (ex_regwr),
    .ex_wbsel    (ex_wbsel),
    .ex_valid    (ex_valid),
    .id_hold     (id_hold)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Operand value chosen by a forwarding code, straight from the code table.
  function automatic logic [31:0] pick(input logic [2:0] code, input logic [31:0] rf);
    if (code == 3'b010) return ex_alu_res;
    if (code == 3'b100) return mem_alu_res;
    if (code == 3'b110) return wb_alu_res;
    if (code == 3'b111) return wb_mem_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_op1 = 0;
    m_op2 = 0;
    m_sc  = 0;
    m_fc  = 0;
  endtask

  // Called with inputs stable and clk low: check id_hold, predict, take an edge.
  task automatic cycle();
    exp_t e;
    bit   hold_exp;
    bit   is_load;
    #1;
    hold_exp = stall && id_valid && !flush;
    chk("id_hold", {31'd0, id_hold}, {31'd0, hold_exp});
    is_load = id_valid && !stall && !flush;
    if (hold_exp && m_sc < 65535) m_sc++;
    if (is_load) begin
      m_op1 = pick(rs1val_cont, id_rs1val);
      m_op2 = pick(rs2val_cont, id_rs2val);
      if ((rs1val_cont != 0 || rs2val_cont != 0) && m_fc < 65535) m_fc++;
      e.rd    = id_rd;
      e.regwr = id_regwr && (id_rd != 0);
      e.wbsel = id_wbsel;
      e.valid = 1'b1;
    end else begin
      e.rd    = 0;
      e.regwr = 0;
      e.wbsel = 0;
      e.valid = 0;
    end
    e.op1 = m_op1;
    e.op2 = m_op2;
    e.sc  = m_sc[15:0];
    e.fc  = m_fc[15:0];
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_inst(input bit v, input logic [4:0] rd, input bit rw, input logic [1:0] wb,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [2:0] c1, input logic [2:0] c2,
                          input bit st, input bit fl);
    id_valid = v; id_rd = rd; id_regwr = rw; id_wbsel = wb;
    id_rs1val = r1; id_rs2val = r2; rs1val_cont = c1; rs2val_cont = c2;
    stall = st; flush = fl;
  endtask

  task automatic set_sources(input logic [31:0] ex, input logic [31:0] mem,
                             input logic [31:0] wba, input logic [31:0] wbm);
    ex_alu_res = ex; mem_alu_res = mem; wb_alu_res = wba; wb_mem_data = wbm;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_op1"},   ex_op1, 0);
    chk({tag, "_op2"},   ex_op2, 0);
    chk({tag, "_rd"},    {27'd0, ex_rd}, 0);
    chk({tag, "_regwr"}, {31'd0, ex_regwr}, 0);
    chk({tag, "_wbsel"}, {30'd0, ex_wbsel}, 0);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 0);
`ifdef FWD_STATS_EN
    chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 0);
    chk({tag, "_fwd_cnt"},   {16'd0, fwd_cnt}, 0);
`endif
  endtask

  // Asynchronous reset pulse inside the low phase, clear of any clock edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per clock edge taken through cycle().
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ex_op1",   ex_op1, e.op1);
      chk("ex_op2",   ex_op2, e.op2);
      chk("ex_rd",    {27'd0, ex_rd}, {27'd0, e.rd});
      chk("ex_regwr", {31'd0, ex_regwr}, {31'd0, e.regwr});
      chk("ex_wbsel", {30'd0, ex_wbsel}, {30'd0, e.wbsel});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
`ifdef FWD_STATS_EN
      chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.sc});
      chk("fwd_cnt",   {16'd0, fwd_cnt},   {16'd0, e.fc});
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_sources(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Forward from EX
    set_sources(32'hAA, 32'hBB, 32'hCC, 32'hDD);
    set_inst(1, 5'd3, 1, 2'd0, 32'h11, 32'h22, 3'b010, 3'b000, 0, 0);
    cycle();
    chk("fwd_ex_op1", ex_op1, 32'hAA);

    // Stall two cycles then release
    set_inst(1, 5'd4, 1, 2'd1, 32'h33, 32'h44, 3'b100, 3'b000, 1, 0);
    cycle();
    cycle();
    set_inst(1, 5'd4, 1, 2'd1, 32'h33, 32'h44, 3'b100, 3'b000, 0, 0);
    cycle();
    chk("post_stall_valid", {31'd0, ex_valid}, 1);

    // Stall and flush together
    set_inst(1, 5'd5, 1, 2'd0, 32'h55, 32'h66, 3'b000, 3'b000, 1, 1);
    cycle();

    // WB forwarding and reserved code
    set_sources(32'hAA, 32'hBB, 32'h5, 32'h7);
    set_inst(1, 5'd6, 0, 2'd1, 32'h1, 32'h2, 3'b110, 3'b111, 0, 0);
    cycle();
    chk("wb_alu_op1", ex_op1, 32'h5);
    chk("wb_mem_op2", ex_op2, 32'h7);
    set_inst(1, 5'd6, 0, 2'd1, 32'h99, 32'h98, 3'b101, 3'b001, 0, 0);
    cycle();
    chk("rsvd_code_op1", ex_op1, 32'h99);

    // Write to x0 suppressed
    set_inst(1, 5'd0, 1, 2'd0, 32'h1, 32'h2, 3'b000, 3'b000, 0, 0);
    cycle();

    // Invalid ID slot
    set_inst(0, 5'd9, 1, 2'd1, 32'h1, 32'h2, 3'b010, 3'b010, 0, 0);
    cycle();

    // Reset mid-stall
    set_inst(1, 5'd7, 1, 2'd1, 32'h77, 32'h78, 3'b010, 3'b000, 1, 0);
    cycle();
    pulse_reset();
    cycle();
    set_inst(1, 5'd7, 1, 2'd1, 32'h77, 32'h78, 3'b010, 3'b000, 0, 0);
    cycle();

`ifdef FWD_STATS_EN
    // Three stall edges, then two forwarded loads
    pulse_reset();
    set_inst(1, 5'd8, 1, 2'd0, 32'h1, 32'h2, 3'b010, 3'b000, 1, 0);
    repeat (3) cycle();
    stall = 0;
    cycle();
    set_inst(1, 5'd9, 1, 2'd0, 32'h1, 32'h2, 3'b000, 3'b100, 0, 0);
    cycle();
    chk("stats_stall3", {16'd0, stall_cnt}, 3);
    chk("stats_fwd2",   {16'd0, fwd_cnt}, 2);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_sources($urandom, $urandom, $urandom, $urandom);
      set_inst(($urandom_range(0, 99) < 85), 5'($urandom), 1'($urandom), 2'($urandom),
               $urandom, $urandom, 3'($urandom), 3'($urandom),
               ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 10));
      cycle();
    end

`ifdef FWD_STATS_EN
    // Drive stall_cnt to saturation and beyond
    set_inst(1, 5'd1, 1, 2'd0, 32'h1, 32'h2, 3'b000, 3'b000, 1, 0);
    while (m_sc < 65535) cycle();
    repeat (4) cycle();
    chk("stall_cnt_saturate", {16'd0, stall_cnt}, 32'hFFFF);
`endif

    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
